multicycle_control: RTL

- Finite-state control unit that sequences the multicycle CPU datapath: PC register, instruction register, synchronous-read register file, ALU, zero-flag flip-flop and the mux2/mux4 selectors.
- Steps each instruction through fetch, decode, execute, memory and writeback states, with a ready handshake on memory accesses.
- Counts retired instructions for the debug/LED display.

---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/control_outdec.sv | 97 +++++++++
 rtl/multicycle_control.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit:
// opcodes, FSM states and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOADI = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_JUMP  = 4'b1011;
  localparam logic [3:0] OP_JZ    = 4'b1100;
  localparam logic [3:0] OP_JNZ   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_RSVD  = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_LOADI_WB = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_BRANCH   = 4'd7,
    S_HALT     = 4'd8
  } state_t;

  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP = 2'b01;

  localparam logic [1:0] WD_SEL_ALU = 2'b00;
  localparam logic [1:0] WD_SEL_MEM = 2'b01;
  localparam logic [1:0] WD_SEL_IMM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/control_outdec.sv
// Combinational strobe decoder: maps the current state (plus opcode, zero
// flag and memory ready) onto the datapath control signals.
module control_outdec
  import cpu_ctrl_pkg::*;
(
  input  logic       kill,
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_we,
  output logic [1:0] wd_sel,
  output logic [2:0] alu_op,
  output logic       z_load,
  output logic       halted
);

  // Strobe decode; everything defaults low so illegal states and reset are inert.
  always_comb begin
    pc_en     = 1'b0;
    pc_src    = PC_SRC_INC;
    ir_en     = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_we    = 1'b0;
    wd_sel    = WD_SEL_ALU;
    alu_op    = ALU_ADD;
    z_load    = 1'b0;
    halted    = 1'b0;
    if (kill) begin
      halted = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          iord     = 1'b0;
          if (mem_ready) begin
            ir_en  = 1'b1;
            pc_en  = 1'b1;
            pc_src = PC_SRC_INC;
          end else begin
            ir_en  = 1'b0;
            pc_en  = 1'b0;
          end
        end
        S_DECODE: begin
          halted = 1'b0;
        end
        S_EXEC: begin
          reg_we = 1'b1;
          wd_sel = WD_SEL_ALU;
          alu_op = opcode[2:0];
          z_load = 1'b1;
        end
        S_LOADI_WB: begin
          reg_we = 1'b1;
          wd_sel = WD_SEL_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_we = 1'b1;
          wd_sel = WD_SEL_MEM;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BRANCH: begin
          pc_src = PC_SRC_JUMP;
          case (opcode)
            OP_JUMP: pc_en = 1'b1;
            OP_JZ:   pc_en = zero;
            OP_JNZ:  pc_en = ~zero;
            default: pc_en = 1'b0;
          endcase
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions; strobe decoding lives in control_outdec.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             ir_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_we,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic             z_load,
  output logic             halted,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] retired_r;
  logic             fetch_done_s;

  assign fetch_done_s = (state_r == S_FETCH) && mem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Retired-instruction counter; an instruction retires when its fetch completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (fetch_done_s) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state logic; unknown encodings fall back to FETCH.
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:   state_nxt_s = S_FETCH;
          OP_RSVD:  state_nxt_s = S_FETCH;
          OP_LOADI: state_nxt_s = S_LOADI_WB;
          OP_LOAD:  state_nxt_s = S_MEM_RD;
          OP_STORE: state_nxt_s = S_MEM_WR;
          OP_JUMP:  state_nxt_s = S_BRANCH;
          OP_JZ:    state_nxt_s = S_BRANCH;
          OP_JNZ:   state_nxt_s = S_BRANCH;
          OP_HALT:  state_nxt_s = S_HALT;
          default: begin
            if (is_alu_op(opcode)) begin
              state_nxt_s = S_EXEC;
            end else begin
              state_nxt_s = S_FETCH;
            end
          end
        endcase
      end
      S_EXEC:     state_nxt_s = S_FETCH;
      S_LOADI_WB: state_nxt_s = S_FETCH;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_nxt_s = S_MEM_WB;
        end else begin
          state_nxt_s = S_MEM_RD;
        end
      end
      S_MEM_WB:   state_nxt_s = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEM_WR;
        end
      end
      S_BRANCH:   state_nxt_s = S_FETCH;
      S_HALT:     state_nxt_s = S_HALT;
      default:    state_nxt_s = S_FETCH;
    endcase
  end

  // While reset is held every visible output is forced to zero.
  assign state_dbg = reset ? 4'b0000 : state_r;
  assign retired   = reset ? {CNT_W{1'b0}} : retired_r;

  control_outdec u_outdec (
    .kill      (reset),
    .state     (state_r),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .ir_en     (ir_en),
    .iord      (iord),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_we    (reg_we),
    .wd_sel    (wd_sel),
    .alu_op    (alu_op),
    .z_load    (z_load),
    .halted    (halted)
  );

endmodule
